// File: rtl/bp_fe_fetch_buffer.sv
// Fetch-block buffer and RVC/RV32 realigner between the I$ data output and the FE queue.
// Buffers whole fetch blocks and emits one instruction per cycle, including block-straddling ones.
module bp_fe_fetch_buffer #(
    parameter int vaddr_width_p        = 39,
    parameter int fetch_halfwords_p    = 4,
    parameter int els_p                = 4,
    parameter int compressed_support_p = 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            fetch_v_i,
    input  logic [vaddr_width_p-1:0]        fetch_pc_i,
    input  logic [16*fetch_halfwords_p-1:0] fetch_data_i,
    input  logic [1:0]                      fetch_exc_i,
    output logic                            fetch_ready_and_o,
    input  logic                            redirect_v_i,
    input  logic [vaddr_width_p-1:0]        redirect_pc_i,
    input  logic                            redirect_resume_i,
    input  logic [15:0]                     redirect_partial_i,
    output logic                            instr_v_o,
    output logic [vaddr_width_p-1:0]        instr_pc_o,
    output logic [31:0]                     instr_o,
    output logic [1:0]                      instr_exc_o,
    output logic                            instr_partial_o,
    input  logic                            instr_yumi_i,
    output logic [$clog2(els_p+1)-1:0]      count_o
);

    localparam int LG_HW = $clog2(fetch_halfwords_p);
    localparam int PTR_W = $clog2(els_p);
    localparam int CNT_W = $clog2(els_p+1);

    localparam logic [CNT_W-1:0] ELS_CNT  = CNT_W'(els_p);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(els_p-1);
    localparam logic [LG_HW-1:0] LAST_OFF = LG_HW'(fetch_halfwords_p-1);

    typedef logic [fetch_halfwords_p-1:0][15:0] block_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_EXC,
        SEL_PARTIAL,
        SEL_RVC,
        SEL_RV32,
        SEL_CAPTURE
    } sel_e;

    logic [vaddr_width_p-1:0] r_pc_mem   [els_p];
    block_t                   r_data_mem [els_p];
    logic [1:0]               r_exc_mem  [els_p];
    logic [LG_HW-1:0]         r_off_mem  [els_p];

    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic [LG_HW-1:0]         r_head_off;
    logic                     r_head_off_v;
    logic                     r_partial_v;
    logic [vaddr_width_p-1:0] r_partial_pc;
    logic [15:0]              r_partial_hw;

    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fire;
    logic [vaddr_width_p-1:0] w_head_pc;
    block_t                   w_head_data;
    logic [1:0]               w_head_exc;
    logic [LG_HW-1:0]         w_off;
    logic [LG_HW-1:0]         w_off_next;
    logic [15:0]              w_hw;
    logic [15:0]              w_hw_next;
    logic                     w_is_rvc;
    logic [vaddr_width_p-1:0] w_off_pc;
    logic [LG_HW:0]           w_adv;
    logic [LG_HW:0]           w_off_sum;
    logic [PTR_W-1:0]         w_wr_ptr_next;
    logic [PTR_W-1:0]         w_rd_ptr_next;
    sel_e                     w_sel;

    assign w_empty           = (r_count == '0);
    assign fetch_ready_and_o = ~reset_i & (r_count < ELS_CNT);
    assign w_push            = fetch_v_i & fetch_ready_and_o & ~redirect_v_i;
    assign count_o           = r_count;

    assign w_head_pc   = r_pc_mem[r_rd_ptr];
    assign w_head_data = r_data_mem[r_rd_ptr];
    assign w_head_exc  = r_exc_mem[r_rd_ptr];

    // A freshly exposed head block starts at its stored start offset; once partly consumed,
    // the running offset register takes over.
    assign w_off      = r_head_off_v ? r_head_off : r_off_mem[r_rd_ptr];
    assign w_off_next = w_off + LG_HW'(1);
    assign w_hw       = w_head_data[w_off];
    assign w_hw_next  = w_head_data[w_off_next];
    assign w_is_rvc   = (compressed_support_p != 0) && (w_hw[1:0] != 2'b11);
    assign w_off_pc   = {w_head_pc[vaddr_width_p-1:LG_HW+1], w_off, 1'b0};

    assign w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);

    // Extraction priority: head exception, pending partial, RVC, in-block RV32, straddle capture.
    always_comb begin
        w_sel = SEL_NONE;
        if (!w_empty) begin
            if (w_head_exc != 2'b00) begin
                w_sel = SEL_EXC;
            end else if (r_partial_v) begin
                w_sel = SEL_PARTIAL;
            end else if (w_is_rvc) begin
                w_sel = SEL_RVC;
            end else if (w_off != LAST_OFF) begin
                w_sel = SEL_RV32;
            end else begin
                w_sel = SEL_CAPTURE;
            end
        end
    end

    always_comb begin
        instr_v_o       = 1'b0;
        instr_pc_o      = '0;
        instr_o         = '0;
        instr_exc_o     = 2'b00;
        instr_partial_o = 1'b0;
        case (w_sel)
            SEL_EXC: begin
                instr_v_o       = 1'b1;
                instr_pc_o      = r_partial_v ? r_partial_pc : w_head_pc;
                instr_exc_o     = w_head_exc;
                instr_partial_o = r_partial_v;
            end
            SEL_PARTIAL: begin
                instr_v_o  = 1'b1;
                instr_pc_o = r_partial_pc;
                instr_o    = {w_hw, r_partial_hw};
            end
            SEL_RVC: begin
                instr_v_o  = 1'b1;
                instr_pc_o = w_off_pc;
                instr_o    = {16'h0000, w_hw};
            end
            SEL_RV32: begin
                instr_v_o  = 1'b1;
                instr_pc_o = w_off_pc;
                instr_o    = {w_hw_next, w_hw};
            end
            default: begin
                instr_v_o = 1'b0;
            end
        endcase
    end

    assign w_fire    = instr_v_o & instr_yumi_i & ~redirect_v_i;
    assign w_adv     = (w_sel == SEL_RV32) ? (LG_HW+1)'(2) : (LG_HW+1)'(1);
    assign w_off_sum = {1'b0, w_off} + w_adv;

    // The straddle capture retires the head block on its own, without a consumer handshake.
    assign w_pop = (w_fire & ((w_sel == SEL_EXC) | w_off_sum[LG_HW]))
                 | ((w_sel == SEL_CAPTURE) & ~redirect_v_i);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= fetch_pc_i;
            r_data_mem[r_wr_ptr] <= block_t'(fetch_data_i);
            r_exc_mem[r_wr_ptr]  <= fetch_exc_i;
            r_off_mem[r_wr_ptr]  <= fetch_pc_i[LG_HW:1];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head_off   <= '0;
            r_head_off_v <= 1'b0;
            r_partial_v  <= 1'b0;
            r_partial_pc <= '0;
            r_partial_hw <= '0;
        end else if (redirect_v_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head_off   <= '0;
            r_head_off_v <= 1'b0;
            r_partial_v  <= redirect_resume_i;
            r_partial_pc <= redirect_pc_i;
            r_partial_hw <= redirect_partial_i;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            if (w_pop) begin
                r_head_off_v <= 1'b0;
            end else if (w_fire) begin
                r_head_off   <= w_off_sum[LG_HW-1:0];
                r_head_off_v <= 1'b1;
            end

            if (w_sel == SEL_CAPTURE) begin
                r_partial_v  <= 1'b1;
                r_partial_pc <= w_off_pc;
                r_partial_hw <= w_hw;
            end else if (w_fire && ((w_sel == SEL_EXC) || (w_sel == SEL_PARTIAL))) begin
                r_partial_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Scoreboard bench for bp_fe_fetch_buffer: a halfword-stream model predicts the instruction
// sequence for every accepted block, and a monitor thread compares each consumed output.
module tb_bp_fe_fetch_buffer;

    localparam int VW  = 39;
    localparam int NH  = 4;
    localparam int ELS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetchV;
    logic [VW-1:0]     fetchPc;
    logic [16*NH-1:0]  fetchData;
    logic [1:0]        fetchExc;
    logic              fetchReady;
    logic              redirectV;
    logic [VW-1:0]     redirectPc;
    logic              redirectResume;
    logic [15:0]       redirectPartial;
    logic              instrV;
    logic [VW-1:0]     instrPc;
    logic [31:0]       instrData;
    logic [1:0]        instrExc;
    logic              instrPartial;
    logic              instrYumi;
    logic [2:0]        countOut;

    logic yumiEn;
    bit   randomYumi;

    typedef struct packed {
        logic [VW-1:0] pc;
        logic [31:0]   instr;
        logic [1:0]    exc;
        logic          partial;
    } exp_t;

    exp_t          expQ[$];
    int            checks;
    int            errors;
    logic          haveLow;
    logic [15:0]   lowHw;
    logic [VW-1:0] lowPc;

    always #5 clk = ~clk;

    assign instrYumi = instrV & yumiEn;

    bp_fe_fetch_buffer #(
        .vaddr_width_p(VW),
        .fetch_halfwords_p(NH),
        .els_p(ELS),
        .compressed_support_p(1)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
        .fetch_v_i(fetchV),
        .fetch_pc_i(fetchPc),
        .fetch_data_i(fetchData),
        .fetch_exc_i(fetchExc),
        .fetch_ready_and_o(fetchReady),
        .redirect_v_i(redirectV),
        .redirect_pc_i(redirectPc),
        .redirect_resume_i(redirectResume),
        .redirect_partial_i(redirectPartial),
        .instr_v_o(instrV),
        .instr_pc_o(instrPc),
        .instr_o(instrData),
        .instr_exc_o(instrExc),
        .instr_partial_o(instrPartial),
        .instr_yumi_i(instrYumi),
        .count_o(countOut)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [16*NH-1:0] mk(input logic [15:0] h0, input logic [15:0] h1,
                                            input logic [15:0] h2, input logic [15:0] h3);
        return {h3, h2, h1, h0};
    endfunction

    function automatic logic [15:0] randHw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'($urandom_range(0, 2));
        return h;
    endfunction

    function automatic void pushExp(input logic [VW-1:0] pc, input logic [31:0] instr,
                                    input logic [1:0] exc, input logic partial);
        exp_t e;
        e.pc      = pc;
        e.instr   = instr;
        e.exc     = exc;
        e.partial = partial;
        expQ.push_back(e);
    endfunction

    // Reference model: walk the block's halfwords from its start offset as a plain stream,
    // pairing a 32-bit low half with whatever halfword comes next in the stream.
    function automatic void modelAccept(input logic [VW-1:0] pc, input logic [16*NH-1:0] data,
                                        input logic [1:0] exc);
        logic [VW-1:0] base;
        logic [VW-1:0] hpc;
        logic [15:0]   h;
        int            start;
        base  = pc & ~VW'(2*NH - 1);
        start = int'((pc >> 1) % NH);
        if (exc != 2'b00) begin
            pushExp(haveLow ? lowPc : pc, 32'h0, exc, haveLow);
            haveLow = 1'b0;
            return;
        end
        for (int off = start; off < NH; off++) begin
            h   = data[16*off +: 16];
            hpc = base + VW'(2*off);
            if (haveLow) begin
                pushExp(lowPc, {h, lowHw}, 2'b00, 1'b0);
                haveLow = 1'b0;
            end else if (h[1:0] != 2'b11) begin
                pushExp(hpc, {16'h0000, h}, 2'b00, 1'b0);
            end else begin
                haveLow = 1'b1;
                lowHw   = h;
                lowPc   = hpc;
            end
        end
    endfunction

    // Called at posedge+1; offers one block until accepted, returns at posedge+1.
    task automatic applyStimulus(input logic [VW-1:0] pc, input logic [16*NH-1:0] data,
                                 input logic [1:0] exc);
        int waited;
        bit done;
        waited    = 0;
        done      = 0;
        fetchV    = 1'b1;
        fetchPc   = pc;
        fetchData = data;
        fetchExc  = exc;
        while (!done) begin
            @(negedge clk);
            if (fetchReady) begin
                modelAccept(pc, data, exc);
                done = 1;
            end else if (++waited > 500) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout actual=ready_low required=accepted pc=%0h", pc);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        fetchV = 1'b0;
    endtask

    task automatic doRedirect(input logic [VW-1:0] pc, input logic resume, input logic [15:0] partial,
                              input logic withFetch);
        redirectV       = 1'b1;
        redirectPc      = pc;
        redirectResume  = resume;
        redirectPartial = partial;
        fetchV          = withFetch;
        fetchPc         = pc + VW'(8);
        fetchData       = mk(randHw(), randHw(), randHw(), randHw());
        fetchExc        = 2'b00;
        @(negedge clk);
        expQ.delete();
        haveLow = resume;
        lowPc   = pc;
        lowHw   = partial;
        @(posedge clk);
        #1;
        redirectV = 1'b0;
        fetchV    = 1'b0;
    endtask

    task automatic drain();
        int  waited;
        bit  done;
        waited = 0;
        done   = 0;
        yumiEn = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (expQ.size() == 0 && countOut == 3'd0 && !instrV) done = 1;
            else if (++waited > 500) done = 1;
        end
        checkOutput("drain_count", 128'(countOut), 128'(0));
        checkOutput("drain_pending", 128'(expQ.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic monitorLoop();
        exp_t act;
        exp_t exp;
        forever begin
            @(negedge clk);
            if (!rst && instrV && instrYumi && !redirectV) begin
                act.pc      = instrPc;
                act.instr   = instrData;
                act.exc     = instrExc;
                act.partial = instrPartial;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_instr actual pc=%0h instr=%0h exc=%0d required=none",
                             instrPc, instrData, instrExc);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("instr{pc,instr,exc,partial}", 128'(act), 128'(exp));
                end
            end
        end
    endtask

    task automatic yumiLoop();
        forever begin
            @(posedge clk);
            #1;
            if (randomYumi) yumiEn = ($urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        haveLow         = 1'b0;
        lowHw           = '0;
        lowPc           = '0;
        randomYumi      = 0;
        yumiEn          = 1'b0;
        rst             = 1'b0;
        fetchV          = 1'b1;
        fetchPc         = 39'h80000000;
        fetchData       = mk(16'h0001, 16'h0001, 16'h0001, 16'h0001);
        fetchExc        = 2'b00;
        redirectV       = 1'b0;
        redirectPc      = '0;
        redirectResume  = 1'b0;
        redirectPartial = '0;
        fork
            monitorLoop();
            yumiLoop();
        join_none

        // Reset held with a block offered: nothing enqueues and every output stays low.
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_count", 128'(countOut), 128'(0));
        checkOutput("reset_instr_v", 128'(instrV), 128'(0));
        checkOutput("reset_instr", 128'(instrData), 128'(0));
        checkOutput("reset_pc", 128'(instrPc), 128'(0));
        checkOutput("reset_exc", 128'(instrExc), 128'(0));
        checkOutput("reset_partial", 128'(instrPartial), 128'(0));
        checkOutput("reset_ready", 128'(fetchReady), 128'(0));
        @(posedge clk);
        #1;
        rst    = 1'b0;
        fetchV = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ready", 128'(fetchReady), 128'(1));
        checkOutput("post_reset_count", 128'(countOut), 128'(0));
        @(posedge clk);
        #1;

        // Mixed RVC/RV32 block.
        yumiEn = 1'b1;
        applyStimulus(39'h80000000, mk(16'h4501, 16'h0013, 16'h0000, 16'h0001), 2'b00);
        drain();

        // Boundary straddle.
        applyStimulus(39'h80000000, mk(16'h0001, 16'h0001, 16'h0001, 16'h0013), 2'b00);
        applyStimulus(39'h80000008, mk(16'h0000, 16'h0001, 16'h0001, 16'h0001), 2'b00);
        drain();

        // Exceptions, without and with a pending partial.
        applyStimulus(39'h80000010, mk(16'h1111, 16'h2222, 16'h3333, 16'h4444), 2'd2);
        drain();
        applyStimulus(39'h80000008, mk(16'h0001, 16'h0001, 16'h0001, 16'h0013), 2'b00);
        applyStimulus(39'h80000010, mk(16'h1111, 16'h2222, 16'h3333, 16'h4444), 2'd2);
        drain();

        // Backpressure: four blocks fill the buffer, the fifth is held until drain starts.
        yumiEn = 1'b0;
        for (int i = 0; i < ELS; i++) begin
            applyStimulus(39'h80001000 + VW'(8*i), mk(randHw(), randHw(), randHw(), randHw()), 2'b00);
        end
        @(negedge clk);
        checkOutput("full_ready", 128'(fetchReady), 128'(0));
        checkOutput("full_count", 128'(countOut), 128'(ELS));
        @(posedge clk);
        #1;
        fetchV    = 1'b1;
        fetchPc   = 39'h80001020;
        fetchData = mk(16'h0001, 16'h0005, 16'h0009, 16'h000d);
        fetchExc  = 2'b00;
        repeat (3) @(negedge clk);
        checkOutput("held_count", 128'(countOut), 128'(ELS));
        checkOutput("held_ready", 128'(fetchReady), 128'(0));
        @(posedge clk);
        #1;
        yumiEn = 1'b1;
        applyStimulus(39'h80001020, mk(16'h0001, 16'h0005, 16'h0009, 16'h000d), 2'b00);
        drain();

        // Redirect with resume while three blocks are buffered and a block is offered.
        yumiEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(39'h80002000 + VW'(8*i), mk(randHw(), randHw(), randHw(), randHw()), 2'b00);
        end
        doRedirect(39'h90000000, 1'b1, 16'h0013, 1'b1);
        @(negedge clk);
        checkOutput("redirect_count", 128'(countOut), 128'(0));
        checkOutput("redirect_instr_v", 128'(instrV), 128'(0));
        @(posedge clk);
        #1;
        yumiEn = 1'b1;
        applyStimulus(39'h90000002, mk(16'hffff, 16'h0000, 16'h0001, 16'h0001), 2'b00);
        drain();

        // Reset in the middle of operation drops buffered blocks.
        yumiEn = 1'b0;
        applyStimulus(39'h80003000, mk(randHw(), randHw(), randHw(), randHw()), 2'b00);
        applyStimulus(39'h80003008, mk(randHw(), randHw(), randHw(), randHw()), 2'b00);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_count", 128'(countOut), 128'(0));
        checkOutput("midreset_instr_v", 128'(instrV), 128'(0));
        expQ.delete();
        haveLow = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_ready", 128'(fetchReady), 128'(1));
        @(posedge clk);
        #1;

        // Randomized traffic with random consumer stalls and occasional redirects.
        randomYumi = 1;
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [VW-1:0] pc;
            r  = $urandom_range(0, 99);
            pc = VW'({$urandom, $urandom}) & ~VW'(1);
            if (r < 5) begin
                doRedirect(pc, 1'($urandom_range(0, 1)), randHw(), 1'($urandom_range(0, 1)));
            end else if (r < 12) begin
                @(posedge clk);
                #1;
            end else begin
                applyStimulus(pc, mk(randHw(), randHw(), randHw(), randHw()),
                              (r < 20) ? 2'($urandom_range(1, 3)) : 2'b00);
            end
        end
        randomYumi = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_fe_fetch_buffer.md
# bp_fe_fetch_buffer

Parametrised fetch-packet buffer and instruction realigner sitting between the I$ data output and the FE queue. Accepts whole fetch blocks of `fetch_halfwords_p` halfwords plus fetch-exception status, and buffers up to `els_p` blocks. Extracts one RVC or RV32 instruction per cycle, including instructions that straddle block boundaries, and supports redirect flush with partial-instruction resume. It generalises the single-block realigner to wider fetch blocks and adds real buffering and in-order exception reporting.

## Interface
Parameters:
- `vaddr_width_p`, 39: virtual address width.
- `fetch_halfwords_p`, 4: halfwords per fetch block; power of two, ≥2.
- `els_p`, 4: buffered fetch blocks; ≥2.
- `compressed_support_p`, 1: when 0, every instruction is 32-bit and PCs are 4-byte aligned.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `fetch_v_i` in 1: fetch block valid.
- `fetch_pc_i` in vaddr_width_p: PC of the first useful halfword. Its low bits `[lg(fetch_halfwords_p):1]` give the start offset within the block.
- `fetch_data_i` in 16*fetch_halfwords_p: block data; halfword 0 is at the LSBs.
- `fetch_exc_i` in 2: exception code. 0 = none, 1 = access fault, 2 = page fault, 3 = ITLB miss.
- `fetch_ready_and_o` out 1: block accepted when `fetch_v_i & fetch_ready_and_o`.
- `redirect_v_i` in 1: flush.
- `redirect_pc_i` in vaddr_width_p: new PC.
- `redirect_resume_i` in 1: a partial instruction is pending at `redirect_pc_i`.
- `redirect_partial_i` in 16: low halfword of the pending partial instruction.
- `instr_v_o` out 1: output valid.
- `instr_pc_o` out vaddr_width_p: instruction PC.
- `instr_o` out 32: instruction; RVC instructions are zero-extended.
- `instr_exc_o` out 2: exception code; nonzero means an exception entry.
- `instr_partial_o` out 1: the exception entry arrived while a partial instruction was pending.
- `instr_yumi_i` in 1: consumer takes the output; legal only when `instr_v_o` is high.
- `count_o` out `$clog2(els_p+1)`: number of buffered blocks.

## Operation
- **Storage:** circular FIFO of `els_p` entries, each holding {pc, data, exc, start offset}. State also includes `head_off_r` (halfword index in the head block), `partial_v_r`, `partial_pc_r` and `partial_hw_r`.
- **Enqueue:** a block is written when `fetch_v_i & fetch_ready_and_o & ~redirect_v_i`. `fetch_ready_and_o = (count_r < els_p)` and does not depend on a same-cycle pop.
- **Current halfword:** `hw = head.data[head_off_r]`. A halfword is RVC when `hw[1:0] != 2'b11` and `compressed_support_p` is 1.
- **Extraction priority, per cycle, when the FIFO is non-empty:**
  1. **Head exception** (`head.exc != 0`): emit `pc = partial_v_r ? partial_pc_r : head.pc`, `exc = head.exc`, `partial = partial_v_r`. On yumi, pop the head and clear `partial_v_r`.
  2. **Partial pending** (`partial_v_r`): emit `{hw, partial_hw_r}` at `partial_pc_r`. On yumi, clear `partial_v_r` and advance 1 halfword.
  3. **RVC:** emit `{16'b0, hw}` at the head-block PC of `head_off_r`. On yumi, advance 1 halfword.
  4. **RV32 with `head_off_r < fetch_halfwords_p-1`:** emit `{hw_next, hw}`. On yumi, advance 2 halfwords.
  5. **RV32 at the last halfword:** `instr_v_o` stays 0. Capture `partial_hw_r = hw` and `partial_pc_r = that PC`, set `partial_v_r`, and pop the head. This takes no consumer handshake.
- **Advance and pop:** when the advance reaches `fetch_halfwords_p`, pop the head and load `head_off_r` from the new head's start offset.
- **Redirect:** has priority over everything.
  - Empties the FIFO, clears `partial_v_r`, and ignores same-cycle `instr_yumi_i` and enqueue.
  - If `redirect_resume_i` is set, it instead sets `partial_v_r`, `partial_pc_r = redirect_pc_i` and `partial_hw_r = redirect_partial_i`.
  - The next block's halfword at its start offset completes the resumed instruction.
- **Arithmetic:** instruction PC = `{head.pc[vaddr_width_p-1:lg+1], head_off_r, 1'b0}`. Offsets wrap modulo `fetch_halfwords_p`, and FIFO pointers wrap modulo `els_p`.

## Timing
- **Reset:** while `reset_i` is high, `count_o`, `instr_v_o`, `instr_o`, `instr_pc_o`, `instr_exc_o` and `instr_partial_o` are 0. `fetch_ready_and_o` is 0 during reset and 1 in the first cycle after deassertion.
- **Latency:** an accepted block can produce `instr_v_o` no earlier than the next cycle; there is no enqueue→output bypass.
- **Output source:** outputs are combinational from registered state only. `instr_v_o` must not depend on `instr_yumi_i`.
- **Throughput:** one instruction per cycle. A boundary-straddling RV32 costs one bubble cycle for the capture step (rule 5).
- **Full:** a same-cycle pop and enqueue while `count_r == els_p` is not possible because ready is low. A pop and enqueue at `count_r < els_p` leaves the count unchanged.
- **Reset mid-operation:** all state clears asynchronously and buffered blocks are lost.

## Test plan
- **Reset:** pulse `reset_i` with `fetch_v_i = 1` -> no enqueue, all outputs 0, `fetch_ready_and_o` = 1 one cycle after deassertion.
- **Mixed RVC/RV32 block:** block at pc 0x80000000, halfwords {0x4501, 0x0013, 0x0000, 0x0001}, yumi held 1 -> outputs (0x80000000, 0x00004501), (0x80000002, 0x00000013), (0x80000006, 0x00000001) on consecutive cycles, then `count_o` = 0.
- **Boundary straddle:** block A at 0x80000000 with halfwords {0x0001, 0x0001, 0x0001, 0x0013}, then block B at 0x80000008 with halfwords {0x0000, 0x0001, 0x0001, 0x0001} -> after A's RVCs, one bubble cycle, then (0x80000006, 0x00000013), then B's RVCs starting at 0x8000000a.
- **Exceptions:** block with `exc` = 2 at 0x80000010 -> single entry with exc 2, pc 0x80000010, partial 0. The same case with a partial pending at 0x8000000e -> pc 0x8000000e, partial 1.
- **Backpressure:** `els_p` = 4, yumi held 0, five blocks offered -> four accepted, ready 0 from the cycle after the 4th, the 5th is held. Asserting yumi then drains everything in order.
- **Redirect with resume:** three blocks buffered, redirect to 0x90000000 with resume and partial 0x0013, plus same-cycle `fetch_v_i` -> next cycle `count_o` = 0 and `instr_v_o` = 0. A subsequent block at pc 0x90000002 with halfword1 = 0x0000 -> (0x90000000, 0x00000013).
